// File: rtl/regfile_mp.sv
// Multi-port integer register file with x0 hardwired to zero, a per-register
// busy scoreboard and a sequenced soft-clear engine. Optional write-to-read
// bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int REG_NUM    = 32,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cpu_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  input  logic                         iss_valid,
  input  logic [ADDR_WIDTH-1:0]        iss_addr,
  input  logic                         clr_req,
  output logic                         clr_busy,
  output logic                         clr_done
);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(REG_NUM - 1);

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   idx, idx_nxt;
  logic [DATA_WIDTH-1:0]   regs [REG_NUM];
  logic [REG_NUM-1:0]      busy, busy_nxt;

  logic [ADDR_WIDTH-1:0]   ra [NUM_RD];
  logic [ADDR_WIDTH-1:0]   wa [NUM_WR];
  logic [DATA_WIDTH-1:0]   wd [NUM_WR];
  logic [NUM_WR-1:0]       wr_ok;
  logic                    idle, iss_ok, clr_start;

  assign idle      = (state == IDLE);
  assign iss_ok    = cpu_en & idle & iss_valid & (iss_addr != '0);
  assign clr_start = cpu_en & idle & clr_req;
  assign clr_busy  = ~idle;
  assign clr_done  = (state == DONE) & cpu_en;

  for (genvar p = 0; p < NUM_WR; p++) begin : g_wr
    assign wa[p]    = wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign wd[p]    = wr_data[p*DATA_WIDTH +: DATA_WIDTH];
    assign wr_ok[p] = cpu_en & idle & wr_en[p] & (wa[p] != '0);
  end

  // Clear sequencer: walks x1..x(REG_NUM-1) one register per enabled cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= FIRST_IDX;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (clr_start) begin
          state_nxt = CLEAR;
          idx_nxt   = FIRST_IDX;
        end
      end
      CLEAR: begin
        if (cpu_en) begin
          if (idx == LAST_IDX) state_nxt = DONE;
          else                 idx_nxt   = idx + FIRST_IDX;
        end
      end
      DONE: begin
        if (cpu_en) begin
          state_nxt = IDLE;
          idx_nxt   = FIRST_IDX;
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = FIRST_IDX;
      end
    endcase
  end

  // NOTE: the array is reset explicitly because a mid-clear reset must leave every register at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else if ((state == CLEAR) && cpu_en) begin
      regs[idx] <= '0;
    end else begin
      // Ascending loop: the highest-indexed port's assignment lands last and wins.
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_ok[p]) regs[wa[p]] <= wd[p];
      end
    end
  end

  // Scoreboard: writes retire a producer, a same-cycle issue re-arms it.
  always_comb begin
    busy_nxt = busy;
    if (clr_start) begin
      busy_nxt = '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_ok[p]) busy_nxt[wa[p]] = 1'b0;
      end
      if (iss_ok) busy_nxt[iss_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [DATA_WIDTH-1:0] data;
    logic                  bsy;

    assign ra[k] = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      data = (ra[k] == '0) ? '0 : regs[ra[k]];
      bsy  = busy[ra[k]] & (ra[k] != '0);
`ifdef REGFILE_BYPASS_EN
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_ok[p] && (wa[p] == ra[k])) begin
          data = wd[p];
          bsy  = iss_ok && (iss_addr == ra[k]);
        end
      end
`endif
    end

    assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = data;
    assign rd_busy[k]                          = bsy;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the 5-stage pipeline, successor to the single-write/dual-read file. Provides NUM_RD combinational read ports and NUM_WR posedge write ports, with x0 hardwired to zero. Adds a per-register busy scoreboard for hazard detection and a sequenced soft-clear engine. Sits between decode (reads, issue) and writeback (writes).

Parameters:
DATA_WIDTH, 32, register width in bits
ADDR_WIDTH, 5, register address width
REG_NUM, 32, number of architectural registers; must equal 2**ADDR_WIDTH
NUM_RD, 2, number of read ports
NUM_WR, 2, number of write ports

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  asynchronous, active-high reset
cpu_en  input  1  global enable; 0 freezes writes, issue, and the clear FSM
rd_addr  input  NUM_RD*ADDR_WIDTH  packed read addresses; port k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH]
rd_data  output  NUM_RD*DATA_WIDTH  packed read data, combinational
rd_busy  output  NUM_RD  scoreboard busy bit of each read address
wr_en  input  NUM_WR  per-port write enable
wr_addr  input  NUM_WR*ADDR_WIDTH  packed write addresses
wr_data  input  NUM_WR*DATA_WIDTH  packed write data
iss_valid  input  1  issue strobe; marks iss_addr busy
iss_addr  input  ADDR_WIDTH  destination register of the issued instruction
clr_req  input  1  soft-clear request, sampled in IDLE only
clr_busy  output  1  high while the clear sequence runs
clr_done  output  1  one-cycle pulse when the clear sequence completes

Behaviour:
- Reset (async): all registers 0, all busy bits 0, FSM=IDLE, clear index=1, clr_busy=0, clr_done=0.
- Read: rd_data[k] = 0 if rd_addr[k]==0, otherwise register contents. Zero-cycle latency.
- Write: on posedge, if cpu_en and FSM==IDLE, each port with wr_en=1 and wr_addr!=0 writes. The result is visible on reads the following cycle (see BYPASS_EN).
- Same-address multi-write: the highest-indexed port wins.
- Writes to x0 are discarded and never set busy.
- Scoreboard:
  - A busy bit is set on posedge when cpu_en & iss_valid & iss_addr!=0.
  - A busy bit is cleared by any accepted write to that address.
  - Simultaneous issue and write to the same address: the bit stays 1, because the new producer wins.
  - rd_busy[k] = 0 for address 0.
- Clear FSM, states IDLE / CLEAR / DONE:
  - IDLE -> CLEAR when cpu_en & clr_req. On entry, all busy bits clear and the index is 1.
  - CLEAR: registers[index] <= 0 each enabled cycle, then index++. At index==REG_NUM-1 the FSM moves to DONE after clearing it, so CLEAR lasts REG_NUM-1 enabled cycles.
  - DONE: clr_done=1 for one cycle, index resets to 1, then the FSM returns to IDLE.
  - clr_busy=1 in CLEAR and DONE.
  - Writes and issues are ignored in CLEAR and DONE. Reads stay live and return partially cleared contents.
  - clr_req outside IDLE is ignored. There is no queuing.
  - cpu_en=0 holds state and index; clr_done is not asserted while stalled.
- Reset mid-clear: the FSM returns to IDLE immediately and all registers read 0.
- Index counter is ADDR_WIDTH bits wide and must not wrap past REG_NUM-1.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: a combinational write-to-read bypass is active. If an accepted write (IDLE, cpu_en, wr_en, wr_addr!=0) matches rd_addr[k] in the same cycle, rd_data[k] returns that wr_data, using highest-port priority. rd_busy[k] is also forced to 0 unless iss_valid targets the same address.
- Undefined: no bypass. Reads reflect only stored state, and a same-cycle write is visible next cycle.

Test Plan:
- Reset, then read all 32 addresses on both ports -> all 0; rd_busy=0; clr_busy=0.
- Write port0 x5=0xDEADBEEF and port1 x5=0x12345678 in the same cycle -> next cycle x5 reads 0x12345678. Write x0=0xFFFFFFFF -> x0 reads 0.
- Issue x7, then 3 idle cycles -> rd_busy=1 for x7. Write x7=0xA5 with iss_valid=1, iss_addr=7 in the same cycle -> busy stays 1. Write x7 alone -> busy 0 next cycle.
- Fill x1..x31 with index+0x100, pulse clr_req:
  - clr_busy rises next cycle.
  - After 31 CLEAR cycles, clr_done pulses once.
  - All reads are 0.
  - A write to x3 during CLEAR is ignored.
  - Repeat with cpu_en=0 for 4 cycles mid-clear -> done is delayed by exactly 4 cycles.
- Assert rst asynchronously (between edges) at clear index 10 -> clr_busy drops immediately, FSM=IDLE, all registers 0.
- With REGFILE_BYPASS_EN: write x9=0x55 while reading x9 -> rd_data=0x55 in the same cycle. Without the macro -> old value that cycle, 0x55 the next.
